dn_mem_arbiter: RTL and testbench

Sequencer and arbiter for the core's shared program/sprite memory port. It accepts the HPS download stream (`dn_*`, from `hps_io` ioctl) and CPU bus cycles, buffers download bytes in a small FIFO, and grants the single synchronous RAM port to one requester per cycle. It also generates the core hold-reset that spans a BIOS download. It sits inside `system`, between the download inputs, the CPU bus and the memory macro.

---
 rtl/dn_mem_arbiter_pkg.sv | 19 +
 rtl/dn_mem_arbiter_fifo.sv | 54 +++++
 rtl/dn_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dn_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dn_mem_arbiter_pkg.sv
// Shared types and constants for the download/CPU memory arbiter.
// Used by the arbiter top and its download FIFO.
package dn_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCpuRd,
        StGrantDn
    } arb_state_t;

    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_SPR  = 8'd3;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } dn_entry_t;

endpackage

// File: rtl/dn_mem_arbiter_fifo.sv
// Small synchronous FIFO buffering download bytes ahead of the RAM port.
// Pushes while full and pops while empty are ignored.
module dn_fifo
    import dn_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  dn_entry_t              wdata,
    input  logic                   pop,
    output dn_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    dn_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dn_mem_arbiter.sv
// Arbitrates the shared program/sprite RAM port between the HPS download
// stream and CPU bus cycles, and holds the core in reset across BIOS loads.
module dn_mem_arbiter
    import dn_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [16:0] SPR_BASE = 17'h10000,
    parameter int unsigned CPU_RUN  = 8,
    parameter int unsigned HOLD     = 16
) (
    input  logic        clk_24,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic [16:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        dn_wr,
    output logic        dn_wait,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset,
    output logic        ovf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = $clog2(CPU_RUN + 1);
    localparam int unsigned HW = $clog2(HOLD + 1);

    arb_state_t    state_q, state_d;
    logic [RW-1:0] run_cnt_q;
    logic [HW-1:0] hold_q;
    logic          core_reset_q;
    logic          ovf_q;

    logic          push_req, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    dn_entry_t     push_entry, fifo_head;
    logic          bios_dl, cpu_req, cpu_ok, cpu_done;

    assign push_req        = dn_wr && (dn_index == IDX_BIOS || dn_index == IDX_SPR);
    assign push_entry.addr = dn_addr + ((dn_index == IDX_SPR) ? SPR_BASE : 17'd0);
    assign push_entry.data = dn_data;

    dn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_24),
        .reset (reset),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bios_dl = dn_download && (dn_index < 8'd2);
    // The CPU is locked out of the port for as long as the core is held in reset.
    assign cpu_req = (cpu_rd | cpu_wr) & ~core_reset_q;
    assign cpu_ok  = cpu_req && ((run_cnt_q < RW'(CPU_RUN)) || fifo_empty);

    always_ff @(posedge clk_24) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cpu_ok)           state_d = cpu_wr ? StIdle : StCpuRd;
                else if (!fifo_empty) state_d = StGrantDn;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_din   = '0;
        fifo_pop  = 1'b0;
        cpu_done  = 1'b0;
        case (state_q)
            StIdle: begin
                if (cpu_ok) begin
                    mem_addr = {1'b0, cpu_addr};
                    if (cpu_wr) begin
                        mem_we    = 1'b1;
                        mem_wdata = cpu_dout;
                        cpu_done  = 1'b1;
                    end
                end
            end
            StCpuRd: begin
                cpu_din  = mem_rdata;
                cpu_done = 1'b1;
            end
            StGrantDn: begin
                mem_we    = 1'b1;
                mem_addr  = fifo_head.addr;
                mem_wdata = fifo_head.data;
                fifo_pop  = 1'b1;
            end
            default: ;
        endcase
        cpu_wait = core_reset_q | ((cpu_rd | cpu_wr) & ~cpu_done);
        if (reset) begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            cpu_din   = '0;
            fifo_pop  = 1'b0;
            cpu_wait  = 1'b0;
        end
    end

    assign dn_wait    = !reset && (fifo_count >= CW'(DEPTH - 1));
    assign core_reset = core_reset_q | reset;
    assign ovf        = ovf_q;

    always_ff @(posedge clk_24) begin
        if (reset || fifo_empty || state_q == StGrantDn) begin
            run_cnt_q <= '0;
        end else if (cpu_done && run_cnt_q != RW'(CPU_RUN)) begin
            run_cnt_q <= run_cnt_q + 1'b1;
        end
    end

    // Hold-reset: high during a BIOS download, while bytes drain, then HOLD cycles.
    always_ff @(posedge clk_24) begin
        if (reset) begin
            core_reset_q <= 1'b1;
            hold_q       <= HW'(HOLD - 1);
        end else if (bios_dl) begin
            core_reset_q <= 1'b1;
            hold_q       <= HW'(HOLD - 1);
        end else if (core_reset_q) begin
            if (!fifo_empty)        hold_q       <= HW'(HOLD - 1);
            else if (hold_q == '0)  core_reset_q <= 1'b0;
            else                    hold_q       <= hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk_24) begin
        if (reset)                      ovf_q <= 1'b0;
        else if (push_req && fifo_full) ovf_q <= 1'b1;
    end

endmodule

// File: tb/tb_dn_mem_arbiter.sv
// Directed bench for dn_mem_arbiter: a RAM model plus a write scoreboard
// that expects every mem_we in the order the stimulus implies.
module tb_dn_mem_arbiter;

    localparam logic [16:0] SPR_BASE = 17'h10000;

    logic        clk_24 = 1'b0;
    logic        reset;
    logic        dn_download, dn_wr;
    logic [7:0]  dn_index, dn_data;
    logic [16:0] dn_addr;
    logic        dn_wait;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_wait;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        core_reset, ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int cpu_seq = 0;
    logic cpu_pend = 1'b0;
    logic obs_wait, obs_pop, obs_dnwait;

    logic [24:0] lo_q[$];
    logic [24:0] hi_q[$];
    logic [7:0]  ram [0:131071];

    dn_mem_arbiter dut (
        .clk_24      (clk_24),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_index    (dn_index),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_wr       (dn_wr),
        .dn_wait     (dn_wait),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_wait    (cpu_wait),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .core_reset  (core_reset),
        .ovf         (ovf)
    );

    always #5 clk_24 = ~clk_24;

    always @(posedge clk_24) cyc <= cyc + 1;

    always @(posedge clk_24) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: sprite-range writes come from the FIFO, the rest in issue order.
    always @(negedge clk_24) begin
        logic [24:0] e;
        if (reset === 1'b0 && mem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (mem_addr[16]) begin
                checks++;
                assert (hi_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_we_hi: observed=%0h expected=none",
                           {mem_addr, mem_wdata});
                end
                if (hi_q.size() != 0) begin
                    e = hi_q.pop_front();
                    chk("we_hi", {7'd0, mem_addr, mem_wdata}, {7'd0, e});
                end
            end else begin
                checks++;
                assert (lo_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_we_lo: observed=%0h expected=none",
                           {mem_addr, mem_wdata});
                end
                if (lo_q.size() != 0) begin
                    e = lo_q.pop_front();
                    chk("we_lo", {7'd0, mem_addr, mem_wdata}, {7'd0, e});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    // One cycle of a saturating CPU write stream, optionally with a sprite push.
    task automatic sat_cycle(input logic do_push, input logic [16:0] paddr,
                             input logic [7:0] pdata, input logic accept);
        step();
        if (!cpu_pend) begin
            cpu_seq++;
            cpu_addr = 16'h2000 + 16'(cpu_seq);
            cpu_dout = 8'(cpu_seq);
            lo_q.push_back({1'b0, cpu_addr, cpu_dout});
        end
        cpu_wr   = 1'b1;
        dn_wr    = do_push;
        dn_index = 8'd3;
        dn_addr  = paddr;
        dn_data  = pdata;
        if (do_push && accept) hi_q.push_back({paddr + SPR_BASE, pdata});
        @(negedge clk_24);
        cpu_pend   = cpu_wait;
        obs_wait   = cpu_wait;
        obs_pop    = mem_we & mem_addr[16];
        obs_dnwait = dn_wait;
    endtask

    task automatic wait_core_low(input int limit, output int n);
        n = 0;
        while (core_reset !== 1'b0 && n < limit) begin
            n++;
            @(negedge clk_24);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pops, gap, stalls, last_pop, k, hi;
        reset = 1'b1;
        dn_download = 1'b0; dn_wr = 1'b0; dn_index = '0; dn_addr = '0; dn_data = '0;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = '0;

        // Reset values
        repeat (2) @(posedge clk_24);
        @(negedge clk_24);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_din", cpu_din, 0);
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_dn_wait", dn_wait, 0);
        chk("rst_core_reset", core_reset, 1);
        step();
        reset = 1'b0;
        @(negedge clk_24);
        chk("hold_cpu_wait", cpu_wait, 1);
        n = 0;
        while (core_reset === 1'b1 && n < 40) begin
            n++;
            @(negedge clk_24);
        end
        chk("post_reset_hold", n, 16);

        // BIOS download, no CPU traffic
        step();
        dn_download = 1'b1; dn_index = 8'd0; dn_addr = 17'h0; dn_data = 8'h11; dn_wr = 1'b1;
        lo_q.push_back({17'h0, 8'h11});
        step();
        dn_addr = 17'h1; dn_data = 8'h22;
        lo_q.push_back({17'h1, 8'h22});
        @(negedge clk_24);
        chk("bios_core_reset", core_reset, 1);
        step();
        dn_wr = 1'b0; dn_download = 1'b0;
        @(negedge clk_24);
        wait_core_low(60, n);
        chk("bios_hold_timeout", core_reset, 0);
        chk("bios_hold_len", cyc - last_we_cyc, 17);
        chk("bios_ram0", ram[0], 8'h11);
        chk("bios_ram1", ram[1], 8'h22);

        // Sprite offset, then index 1 strobes that must not reach RAM
        step();
        dn_download = 1'b1; dn_index = 8'd3; dn_addr = 17'h5; dn_data = 8'hA5; dn_wr = 1'b1;
        hi_q.push_back({17'h10005, 8'hA5});
        step();
        dn_wr = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_24);
            if (core_reset !== 1'b0) hi++;
        end
        chk("spr_no_core_reset", hi, 0);
        chk("spr_ram", ram[17'h10005], 8'hA5);
        step();
        dn_index = 8'd1; dn_addr = 17'h7; dn_data = 8'h77; dn_wr = 1'b1;
        step();
        dn_wr = 1'b0;
        @(negedge clk_24);
        chk("idx1_core_reset", core_reset, 1);
        repeat (4) @(negedge clk_24);
        step();
        dn_download = 1'b0;
        @(negedge clk_24);
        wait_core_low(40, n);
        chk("idx1_hold_timeout", core_reset, 0);
        chk("spr_lo_q_drained", lo_q.size(), 0);
        chk("spr_hi_q_drained", hi_q.size(), 0);

        // CPU write then read back
        step();
        @(negedge clk_24);
        chk("cpu_idle_wait", cpu_wait, 0);
        step();
        cpu_wr = 1'b1; cpu_addr = 16'h1234; cpu_dout = 8'h5A;
        lo_q.push_back({17'h01234, 8'h5A});
        @(negedge clk_24);
        chk("wr_wait", cpu_wait, 0);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 17'h01234);
        chk("wr_data", mem_wdata, 8'h5A);
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        @(negedge clk_24);
        chk("rd0_wait", cpu_wait, 1);
        chk("rd0_we", mem_we, 0);
        chk("rd0_addr", mem_addr, 17'h01234);
        @(negedge clk_24);
        chk("rd1_wait", cpu_wait, 0);
        chk("rd1_din", cpu_din, 8'h5A);
        step();
        cpu_rd = 1'b0;

        // Starvation guard: 3 buffered bytes against continuous CPU writes
        pops = 0; gap = 0; stalls = 0; last_pop = 99;
        for (int i = 0; i < 34; i++) begin
            sat_cycle(i < 3, 17'(i), 8'(8'hC0 + i), 1'b1);
            if (obs_pop) begin
                pops++;
                chk("starve_gap", gap, (pops == 1) ? 9 : 8);
                chk("starve_pop_wait", obs_wait, 1);
                gap = 0;
                last_pop = i;
            end else if (!obs_wait) begin
                gap++;
            end
            if (obs_wait) stalls++;
        end
        chk("starve_pops", pops, 3);
        chk("starve_stalls", stalls, 6);
        chk("starve_within_30", (last_pop <= 30), 1);

        // Back-pressure: a push on every cycle while the CPU saturates the port
        for (int i = 0; i < 50; i++) begin
            sat_cycle(i < 5, 17'(17'h100 + i), 8'(8'hD0 + i), i < 4);
            if (i <= 5) chk("bp_dn_wait", obs_dnwait, (i >= 3));
            if (i == 4) chk("bp_ovf_before", ovf, 0);
            if (i == 5) chk("bp_ovf_after", ovf, 1);
        end
        k = 0;
        while (cpu_pend && k < 20) begin
            sat_cycle(1'b0, 17'h0, 8'h0, 1'b0);
            k++;
        end
        step();
        cpu_wr = 1'b0; dn_wr = 1'b0;
        @(negedge clk_24);
        chk("bp_hi_q_drained", hi_q.size(), 0);
        chk("bp_lo_q_drained", lo_q.size(), 0);
        chk("bp_ovf_sticky", ovf, 1);

        // Reset with two bytes buffered
        step();
        dn_index = 8'd3; dn_addr = 17'h40; dn_data = 8'hE0; dn_wr = 1'b1;
        step();
        dn_addr = 17'h41; dn_data = 8'hE1;
        step();
        dn_wr = 1'b0; reset = 1'b1;
        @(negedge clk_24);
        chk("rst_mid_buffered", dut.fifo_count, 2);
        step();
        reset = 1'b0;
        @(negedge clk_24);
        chk("rst_mid_count", dut.fifo_count, 0);
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_core_reset", core_reset, 1);
        chk("rst_mid_ovf", ovf, 0);
        wait_core_low(40, n);
        chk("rst_mid_hold_timeout", core_reset, 0);
        chk("final_hi_q", hi_q.size(), 0);
        chk("final_lo_q", lo_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
